// File: rtl/msrh_dcache_fill_arb.sv
// L1D refill / store arbiter: two-stage refill pipe (LRQ lookup, then line placement)
// sharing per-bank data-array write ports with stores. MSRH_DCACHE_WBUF_EN adds a store write buffer.
module msrh_dcache_fill_arb #(
   parameter int LINE_W      = 512,
   parameter int BEAT_NUM    = 4,
   parameter int BANK_NUM    = 2,
   parameter int PADDR_W     = 56,
   parameter int TAG_W       = 8,
   parameter int LRQ_ENTRY_W = 3,
   parameter int WBUF_DEPTH  = 4
) (
   input  logic                             i_clk,
   input  logic                             i_reset_n,
   input  logic                             i_l2_resp_valid,
   input  logic [TAG_W-1:0]                 i_l2_resp_tag,
   input  logic [LINE_W/BEAT_NUM-1:0]       i_l2_resp_data,
   output logic                             o_lrq_search_valid,
   output logic [LRQ_ENTRY_W-1:0]           o_lrq_search_index,
   input  logic [PADDR_W-1:0]               i_lrq_search_paddr,
   input  logic                             i_wr_valid,
   input  logic [PADDR_W-1:0]               i_wr_paddr,
   input  logic [LINE_W-1:0]                i_wr_data,
   input  logic [LINE_W/8-1:0]              i_wr_be,
   output logic                             o_wr_conflict,
   output logic [BANK_NUM-1:0]              o_upd_valid,
   output logic [BANK_NUM*PADDR_W-1:0]      o_upd_paddr,
   output logic [BANK_NUM*LINE_W-1:0]       o_upd_data,
   output logic [BANK_NUM*LINE_W/8-1:0]     o_upd_be
);

   localparam int BEAT_W    = LINE_W / BEAT_NUM;
   localparam int BE_W      = LINE_W / 8;
   localparam int BEAT_BE_W = BEAT_W / 8;
   localparam int OFF_W     = $clog2(LINE_W / 8);
   localparam int BANK_W    = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1;
   localparam int CNT_W     = (BEAT_NUM > 1) ? $clog2(BEAT_NUM) : 1;

   logic                   resp_accept;
   logic [CNT_W-1:0]       beat_cnt;
   logic                   rp1_valid;
   logic [LRQ_ENTRY_W-1:0] rp1_index;
   logic [BEAT_W-1:0]      rp1_data;
   logic [CNT_W-1:0]       rp1_beat;
   logic                   rp2_valid;
   logic [PADDR_W-1:0]     rp2_paddr;
   logic [LINE_W-1:0]      rp2_data;
   logic [BE_W-1:0]        rp2_be;
   logic [BANK_W-1:0]      rp2_bank;
   logic [BANK_W-1:0]      wr_bank;
   logic                   wr_req;
   logic                   wr_direct;
   logic                   unused_tag_bits;

   // Only tags whose upper field is 2'b00 belong to L1D; the middle tag bits carry nothing here.
   assign resp_accept     = i_l2_resp_valid && (i_l2_resp_tag[TAG_W-1 -: 2] == 2'b00);
   assign unused_tag_bits = ^i_l2_resp_tag[TAG_W-3:LRQ_ENTRY_W];

   assign o_lrq_search_valid = rp1_valid;
   assign o_lrq_search_index = rp1_valid ? rp1_index : '0;

   assign rp2_bank = (BANK_NUM > 1) ? rp2_paddr[OFF_W +: BANK_W] : '0;
   assign wr_bank  = (BANK_NUM > 1) ? i_wr_paddr[OFF_W +: BANK_W] : '0;
   assign wr_req   = i_wr_valid && i_reset_n;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         beat_cnt  <= '0;
         rp1_valid <= 1'b0;
         rp2_valid <= 1'b0;
      end else begin
         rp1_valid <= resp_accept;
         rp2_valid <= rp1_valid;
         if (resp_accept) begin
            beat_cnt <= (beat_cnt == CNT_W'(BEAT_NUM - 1)) ? '0 : beat_cnt + 1'b1;
         end
      end
   end

   // Payload registers are qualified by the valid bits above and need no reset.
   always_ff @(posedge i_clk) begin
      if (resp_accept) begin
         rp1_index <= i_l2_resp_tag[LRQ_ENTRY_W-1:0];
         rp1_data  <= i_l2_resp_data;
         rp1_beat  <= beat_cnt;
      end
      if (rp1_valid) begin
         rp2_paddr <= i_lrq_search_paddr;
         rp2_data  <= LINE_W'(rp1_data) << (rp1_beat * BEAT_W);
         rp2_be    <= BE_W'({BEAT_BE_W{1'b1}}) << (rp1_beat * BEAT_BE_W);
      end
   end

`ifdef MSRH_DCACHE_WBUF_EN
   localparam int PTR_W = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;

   logic [PADDR_W-1:0] wb_paddr [WBUF_DEPTH];
   logic [LINE_W-1:0]  wb_data  [WBUF_DEPTH];
   logic [BE_W-1:0]    wb_be    [WBUF_DEPTH];
   logic [PTR_W-1:0]   wb_wptr;
   logic [PTR_W-1:0]   wb_rptr;
   logic [PTR_W:0]     wb_count;
   logic               wb_push;
   logic               wb_pop;
   logic               wb_full;
   logic [BANK_W-1:0]  head_bank;

   assign wb_full   = (wb_count == (PTR_W+1)'(WBUF_DEPTH));
   assign head_bank = (BANK_NUM > 1) ? wb_paddr[wb_rptr][OFF_W +: BANK_W] : '0;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         wb_wptr  <= '0;
         wb_rptr  <= '0;
         wb_count <= '0;
      end else begin
         if (wb_push) wb_wptr <= wb_wptr + 1'b1;
         if (wb_pop)  wb_rptr <= wb_rptr + 1'b1;
         case ({wb_push, wb_pop})
            2'b10:   wb_count <= wb_count + 1'b1;
            2'b01:   wb_count <= wb_count - 1'b1;
            default: wb_count <= wb_count;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (wb_push) begin
         wb_paddr[wb_wptr] <= i_wr_paddr;
         wb_data[wb_wptr]  <= i_wr_data;
         wb_be[wb_wptr]    <= i_wr_be;
      end
   end
`endif

   always_comb begin
      o_upd_valid   = '0;
      o_upd_paddr   = '0;
      o_upd_data    = '0;
      o_upd_be      = '0;
      o_wr_conflict = 1'b0;
      wr_direct     = 1'b0;
`ifdef MSRH_DCACHE_WBUF_EN
      wb_push = 1'b0;
      wb_pop  = (wb_count != '0) && !(rp2_valid && (rp2_bank == head_bank));
      // A store bypasses the buffer only when nothing older is waiting, keeping store order.
      wr_direct     = wr_req && (wb_count == '0) && !(rp2_valid && (rp2_bank == wr_bank));
      o_wr_conflict = wr_req && !wr_direct && wb_full;
      wb_push       = wr_req && !wr_direct && !wb_full;
`else
      wr_direct     = wr_req && !(rp2_valid && (rp2_bank == wr_bank));
      o_wr_conflict = wr_req && !wr_direct;
`endif
      for (int b = 0; b < BANK_NUM; b++) begin
         if (rp2_valid && (rp2_bank == BANK_W'(b))) begin
            o_upd_valid[b]                  = 1'b1;
            o_upd_paddr[b*PADDR_W +: PADDR_W] = rp2_paddr;
            o_upd_data[b*LINE_W +: LINE_W]    = rp2_data;
            o_upd_be[b*BE_W +: BE_W]          = rp2_be;
`ifdef MSRH_DCACHE_WBUF_EN
         end else if (wb_pop && (head_bank == BANK_W'(b))) begin
            o_upd_valid[b]                  = 1'b1;
            o_upd_paddr[b*PADDR_W +: PADDR_W] = wb_paddr[wb_rptr];
            o_upd_data[b*LINE_W +: LINE_W]    = wb_data[wb_rptr];
            o_upd_be[b*BE_W +: BE_W]          = wb_be[wb_rptr];
`endif
         end else if (wr_direct && (wr_bank == BANK_W'(b))) begin
            o_upd_valid[b]                  = 1'b1;
            o_upd_paddr[b*PADDR_W +: PADDR_W] = i_wr_paddr;
            o_upd_data[b*LINE_W +: LINE_W]    = i_wr_data;
            o_upd_be[b*BE_W +: BE_W]          = i_wr_be;
         end
      end
   end

endmodule

// File: doc/msrh_dcache_fill_arb.md
MSRH_DCACHE_FILL_ARB -- requirements
Module: msrh_dcache_fill_arb

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  LINE_W, 512, cache line width in bits
  BEAT_NUM, 4, L2 refill beats per line; beat width = LINE_W/BEAT_NUM
  BANK_NUM, 2, data-array banks (power of 2)
  PADDR_W, 56, physical address width
  TAG_W, 8, L2 response tag width
  LRQ_ENTRY_W, 3, LRQ index width
  WBUF_DEPTH, 4, store write buffer entries (power of 2)
REQ-002 Ports (name, direction, width, meaning), one per line:
  i_clk  in  1  clock
  i_reset_n  in  1  reset, asynchronous, active-low
  i_l2_resp_valid  in  1  L2 refill beat valid
  i_l2_resp_tag  in  TAG_W  tag; [TAG_W-1:TAG_W-2] upper tag, [LRQ_ENTRY_W-1:0] LRQ index
  i_l2_resp_data  in  LINE_W/BEAT_NUM  beat data
  o_lrq_search_valid  out  1  LRQ lookup request
  o_lrq_search_index  out  LRQ_ENTRY_W  LRQ index to look up
  i_lrq_search_paddr  in  PADDR_W  line paddr of looked-up entry, same cycle
  i_wr_valid  in  1  store write request
  i_wr_paddr  in  PADDR_W  store paddr
  i_wr_data  in  LINE_W  store data, line-aligned
  i_wr_be  in  LINE_W/8  store byte enables
  o_wr_conflict  out  1  store not accepted this cycle; requester retries
  o_upd_valid  out  BANK_NUM  per-bank array write strobe
  o_upd_paddr  out  BANK_NUM*PADDR_W  per-bank write address
  o_upd_data  out  BANK_NUM*LINE_W  per-bank write data
  o_upd_be  out  BANK_NUM*LINE_W/8  per-bank byte enables

Function
REQ-003 Bank of an address SHALL be paddr[log2(LINE_W/8) +: log2(BANK_NUM)].
REQ-004 RP1: beat accepted iff i_l2_resp_valid and upper tag == 2'b00 (L1D); tag index and data registered; o_lrq_search_valid/index driven from RP1 registers.
REQ-005 Beat counter SHALL increment per accepted beat, wrap BEAT_NUM-1 -> 0; beats of one refill are never interleaved with another refill; gaps between beats allowed.
REQ-006 RP2: register i_lrq_search_paddr, beat data placed at slice [beat*LINE_W/BEAT_NUM], be set only for that slice's bytes.
REQ-007 Refill update latency: beat at cycle N SHALL appear on its bank's o_upd_* at N+2; refill has absolute priority on its bank.
REQ-008 Per-bank source priority: RP2 refill > write buffer head > incoming store; at most one write per bank per cycle; other banks proceed in parallel.
REQ-009 Incoming store goes directly to its bank only if buffer empty and bank free; otherwise enqueued (order preserved); o_wr_conflict=1 only when enqueue needed and buffer full (even if pop same cycle).
REQ-010 Buffer pops head when head's bank is not taken by refill; push and pop same cycle allowed; pointers wrap modulo WBUF_DEPTH.
REQ-011 o_upd_* and o_wr_conflict combinational from RP2 registers, buffer head and store inputs; all unselected bank fields drive 0.

Reset
REQ-012 On i_reset_n low: RP1/RP2 valid, beat counter, buffer pointers/count SHALL clear asynchronously; all outputs 0; partially received refill discarded.
REQ-013 First beat after reset SHALL be treated as beat 0.

Configuration
REQ-014 Macro MSRH_DCACHE_WBUF_EN: defined -> write buffer per REQ-009/010; undefined -> no buffer, o_wr_conflict = i_wr_valid & RP2 refill valid to same bank, conflicting store not written.

Verification
REQ-015 4-beat refill tag 0x03, paddr 0x1000 -> bank0 writes at N+2..N+5, be slices 0x..FFFF per beat, data in correct slice.
REQ-016 Response with upper tag 2'b01 -> no search, no update, beat counter unchanged.
REQ-017 Refill on bank0 + store to paddr 0x1040 (bank1) same cycle -> both o_upd_valid bits set, o_wr_conflict=0.
REQ-018 WBUF_EN: 5 stores to bank0 during 4-beat refill -> 4 enqueued, 5th conflict=1; drained in order after refill.
REQ-019 Without WBUF_EN: store to bank0 during refill -> o_wr_conflict=1, only refill written.
REQ-020 Reset asserted after beat 2 -> outputs 0; next refill writes beat 0 slice first.
